// File: rtl/sgpr_recovery_if.sv
// Signal bundle between the recovery sequencer and the lockstep cores / shared GPR.
// The controller takes the master modport; the core/GPR side takes slave.
interface sgpr_recovery_if;
  logic        mismatch_i;
  logic        halt_ack_a_i;
  logic        halt_ack_b_i;
  logic        halt_o;
  logic [4:0]  sgpr_raddr_o;
  logic [31:0] sgpr_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        flush_o;
  logic        busy_o;
  logic        fail_o;
  logic [7:0]  err_count_o;

  modport master (
    input  mismatch_i, halt_ack_a_i, halt_ack_b_i, sgpr_rdata_i,
    output halt_o, sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           flush_o, busy_o, fail_o, err_count_o
  );

  modport slave (
    output mismatch_i, halt_ack_a_i, halt_ack_b_i, sgpr_rdata_i,
    input  halt_o, sgpr_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           flush_o, busy_o, fail_o, err_count_o
  );
endinterface

// File: rtl/sgpr_recovery_ctrl.sv
// Lockstep recovery sequencer: halts both cores on a GPR mismatch, replays x1..x31
// from the shared GPR into both private register files, then flushes/restarts them.
module sgpr_recovery_ctrl #(
  parameter int MAX_RETRY    = 3,
  parameter int WINDOW       = 1024,
  parameter int HALT_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  sgpr_recovery_if.master bus
);

  localparam int RETRY_W = (MAX_RETRY > 0)    ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WIN_W   = (WINDOW > 2)       ? $clog2(WINDOW)        : 1;
  localparam int TMO_W   = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT)  : 1;

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(HALT_TIMEOUT - 1);
  localparam logic [4:0]         LAST_REG  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_COPY,
    S_DRAIN,
    S_RESUME,
    S_FAIL
  } state_e;

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic [4:0]           raddr_q, raddr_d;
  logic [7:0]           err_q, err_d;

  // Registered copies of the outputs, computed from the next state.
  logic                 halt_q, halt_d;
  logic                 busy_q, busy_d;
  logic                 flush_q, flush_d;
  logic                 fail_q, fail_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;

  // Next-state and counter logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    win_d   = win_q;
    tmo_d   = '0;
    ack_a_d = ack_a_q;
    ack_b_d = ack_b_q;
    raddr_d = '0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        if (bus.mismatch_i) begin
          win_d = '0;
          err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_HALT_WAIT;
          end else begin
            state_d = S_FAIL;
          end
        end else if (retry_q != '0) begin
          // A full quiet window forgives all earlier recoveries.
          if (win_q == WIN_LAST) begin
            win_d   = '0;
            retry_d = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end

      S_HALT_WAIT: begin
        ack_a_d = ack_a_q | bus.halt_ack_a_i;
        ack_b_d = ack_b_q | bus.halt_ack_b_i;
        if (ack_a_q && ack_b_q) begin
          state_d = S_COPY;
          raddr_d = 5'd1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_COPY: begin
        if (raddr_q == LAST_REG) begin
          state_d = S_DRAIN;
        end else begin
          raddr_d = raddr_q + 5'd1;
        end
      end

      S_DRAIN: state_d = S_RESUME;

      S_RESUME: begin
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        win_d   = '0;
        state_d = S_IDLE;
      end

      S_FAIL: state_d = S_FAIL;

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The write strobe lags the read by one cycle so that it lines
  // up with the shared GPR's registered read data.
  always_comb begin
    halt_d  = (state_d == S_HALT_WAIT) || (state_d == S_COPY) ||
              (state_d == S_DRAIN)     || (state_d == S_FAIL);
    busy_d  = (state_d == S_HALT_WAIT) || (state_d == S_COPY) ||
              (state_d == S_DRAIN)     || (state_d == S_RESUME);
    flush_d = (state_d == S_RESUME);
    fail_d  = (state_d == S_FAIL);
    we_d    = (state_q == S_COPY);
    waddr_d = (state_q == S_COPY) ? raddr_q : 5'd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      win_q   <= '0;
      tmo_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      raddr_q <= '0;
      err_q   <= '0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      flush_q <= 1'b0;
      fail_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      win_q   <= win_d;
      tmo_q   <= tmo_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
      flush_q <= flush_d;
      fail_q  <= fail_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
    end
  end

  assign bus.halt_o       = halt_q;
  assign bus.busy_o       = busy_q;
  assign bus.flush_o      = flush_q;
  assign bus.fail_o       = fail_q;
  assign bus.sgpr_raddr_o = raddr_q;
  assign bus.rf_we_o      = we_q;
  assign bus.rf_waddr_o   = waddr_q;
  // Read data arrives in the write cycle, so it is forwarded rather than re-registered.
  assign bus.rf_wdata_o   = we_q ? bus.sgpr_rdata_i : 32'd0;
  assign bus.err_count_o  = err_q;

endmodule

// File: tb/tb_sgpr_recovery_ctrl.sv
// Directed bench for sgpr_recovery_ctrl: a default-parameter instance for the
// recovery/timeout/retry scenarios and a large-MAX_RETRY instance for saturation.
module tb_sgpr_recovery_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sgpr_recovery_if bus();
  sgpr_recovery_if sbus();

  sgpr_recovery_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sgpr_recovery_ctrl #(.MAX_RETRY(511)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Shared-GPR model: xN holds 100+N, read data registered one cycle after address.
  always @(posedge clk) begin
    bus.sgpr_rdata_i  <= 32'd100 + 32'(bus.sgpr_raddr_o);
    sbus.sgpr_rdata_i <= 32'd100 + 32'(sbus.sgpr_raddr_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.mismatch_i   = 1'b0;
    bus.halt_ack_a_i = 1'b0;
    bus.halt_ack_b_i = 1'b0;
    sbus.mismatch_i   = 1'b0;
    sbus.halt_ack_a_i = 1'b0;
    sbus.halt_ack_b_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Mismatch driven in cycle 0; returns in cycle 1 (after the sampling edge).
  task automatic pulse_mismatch();
    bus.mismatch_i = 1'b1;
    tick();
    bus.mismatch_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (bus.busy_o && n < 100) begin
      tick();
      n++;
    end
    ok = !bus.busy_o;
  endtask

  // Observes a recovery from cycle 'start' until one cycle after the flush pulse.
  task automatic watch(input int start, input int budget, output int nw, output bit seq_ok,
                       output int first_we, output int last_we, output int flush_at,
                       output int nflush, output bit halt_at_flush);
    int c = start;
    nw = 0; seq_ok = 1'b1; first_we = -1; last_we = -1;
    flush_at = -1; nflush = 0; halt_at_flush = 1'b1;
    while (c < start + budget && !(nflush > 0 && c > flush_at)) begin
      tick();
      c++;
      if (bus.rf_we_o === 1'b1) begin
        if (bus.rf_waddr_o !== 5'(nw + 1) || bus.rf_wdata_o !== 32'(101 + nw)) seq_ok = 1'b0;
        if (nw == 0) first_we = c;
        last_we = c;
        nw++;
      end
      if (bus.flush_o === 1'b1) begin
        nflush++;
        flush_at = c;
        halt_at_flush = bus.halt_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.halt_o !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b want=0", bus.halt_o); end
    total++; if (bus.busy_o !== 1'b0 || bus.fail_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      bad++; $display("FAIL reset_flags busy=%b fail=%b flush=%b want=000", bus.busy_o, bus.fail_o, bus.flush_o); end
    total++; if (bus.rf_we_o !== 1'b0 || bus.rf_waddr_o !== 5'd0 || bus.sgpr_raddr_o !== 5'd0) begin
      bad++; $display("FAIL reset_addr we=%b waddr=%0d raddr=%0d want=0", bus.rf_we_o, bus.rf_waddr_o, bus.sgpr_raddr_o); end
    total++; if (bus.err_count_o !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", bus.err_count_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    total++; if (bus.busy_o !== 1'b0 || bus.halt_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy=%b halt=%b want=00", bus.busy_o, bus.halt_o); end
  endtask

  task automatic test_basic();
    int nw, fw, lw, fa, nf;
    bit ok, hf;
    do_reset();
    bus.halt_ack_a_i = 1'b1;
    bus.halt_ack_b_i = 1'b1;
    // A stray mismatch during the copy must be ignored.
    fork
      begin
        repeat (20) tick();
        bus.mismatch_i = 1'b1;
        tick();
        bus.mismatch_i = 1'b0;
      end
    join_none
    pulse_mismatch();
    total++; if (bus.halt_o !== 1'b1) begin bad++; $display("FAIL basic_halt got=%b want=1", bus.halt_o); end
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL basic_err got=%0d want=1", bus.err_count_o); end
    watch(1, 80, nw, ok, fw, lw, fa, nf, hf);
    total++; if (nw !== 31) begin bad++; $display("FAIL basic_nwrites got=%0d want=31", nw); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_sequence got=%b want=1", ok); end
    total++; if (fw !== 4 || lw !== 34) begin bad++; $display("FAIL basic_write_window got=%0d..%0d want=4..34", fw, lw); end
    // Cycle 35 after the sampling edge = cycle 36 counting the mismatch cycle as 1.
    total++; if (fa !== 35 || nf !== 1) begin bad++; $display("FAIL basic_flush at=%0d n=%0d want at=35 n=1", fa, nf); end
    total++; if (hf !== 1'b0) begin bad++; $display("FAIL basic_halt_in_resume got=%b want=0", hf); end
    total++; if (bus.halt_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      bad++; $display("FAIL basic_after halt=%b busy=%b flush=%b want=000", bus.halt_o, bus.busy_o, bus.flush_o); end
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL basic_err_final got=%0d want=1", bus.err_count_o); end
    clear_inputs();
  endtask

  task automatic test_skewed_acks();
    int nw, fw, lw, fa, nf;
    bit ok, hf;
    do_reset();
    fork
      begin
        repeat (3) tick();
        bus.halt_ack_b_i = 1'b1;
        repeat (5) tick();
        bus.halt_ack_a_i = 1'b1;
        tick();
        bus.halt_ack_a_i = 1'b0;
      end
    join_none
    pulse_mismatch();
    // ack_a pulses in cycle 8, is latched for cycle 9, COPY starts cycle 10.
    watch(1, 80, nw, ok, fw, lw, fa, nf, hf);
    total++; if (fw !== 11 || lw !== 41) begin bad++; $display("FAIL skew_write_window got=%0d..%0d want=11..41", fw, lw); end
    total++; if (nw !== 31 || ok !== 1'b1) begin bad++; $display("FAIL skew_writes n=%0d ok=%b want n=31 ok=1", nw, ok); end
    total++; if (fa !== 42 || nf !== 1) begin bad++; $display("FAIL skew_flush at=%0d n=%0d want at=42 n=1", fa, nf); end
    clear_inputs();
  endtask

  task automatic test_halt_timeout();
    bit stray = 1'b0;
    do_reset();
    pulse_mismatch();
    repeat (63) tick();
    total++; if (bus.fail_o !== 1'b0 || bus.halt_o !== 1'b1) begin
      bad++; $display("FAIL tmo_before fail=%b halt=%b want fail=0 halt=1", bus.fail_o, bus.halt_o); end
    tick();
    total++; if (bus.fail_o !== 1'b1 || bus.halt_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL tmo_enter fail=%b halt=%b busy=%b want 1 1 0", bus.fail_o, bus.halt_o, bus.busy_o); end
    bus.mismatch_i   = 1'b1;
    bus.halt_ack_a_i = 1'b1;
    bus.halt_ack_b_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fail_o !== 1'b1 || bus.halt_o !== 1'b1 || bus.rf_we_o !== 1'b0 ||
          bus.flush_o !== 1'b0 || bus.sgpr_raddr_o !== 5'd0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL tmo_sticky got_stray=%b want=0", stray); end
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL tmo_err got=%0d want=1", bus.err_count_o); end
    clear_inputs();
  endtask

  task automatic test_retry_budget();
    bit ok;
    bit all_ok = 1'b1;
    do_reset();
    bus.halt_ack_a_i = 1'b1;
    bus.halt_ack_b_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_mismatch();
      wait_idle(ok);
      all_ok &= ok;
      repeat (10) tick();
    end
    total++; if (all_ok !== 1'b1 || bus.err_count_o !== 8'd3) begin
      bad++; $display("FAIL retry_three ok=%b err=%0d want ok=1 err=3", all_ok, bus.err_count_o); end
    pulse_mismatch();
    total++; if (bus.fail_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.halt_o !== 1'b1) begin
      bad++; $display("FAIL retry_fourth fail=%b busy=%b halt=%b want 1 0 1", bus.fail_o, bus.busy_o, bus.halt_o); end
    total++; if (bus.err_count_o !== 8'd4) begin bad++; $display("FAIL retry_err got=%0d want=4", bus.err_count_o); end

    do_reset();
    bus.halt_ack_a_i = 1'b1;
    bus.halt_ack_b_i = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_mismatch();
      wait_idle(ok);
      all_ok &= ok;
      repeat (10) tick();
    end
    repeat (1100) tick();
    pulse_mismatch();
    total++; if (bus.fail_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++; $display("FAIL window_fourth fail=%b busy=%b want 0 1", bus.fail_o, bus.busy_o); end
    wait_idle(ok);
    all_ok &= ok;
    total++; if (all_ok !== 1'b1 || bus.err_count_o !== 8'd4 || bus.fail_o !== 1'b0) begin
      bad++; $display("FAIL window_done ok=%b err=%0d fail=%b want 1 4 0", all_ok, bus.err_count_o, bus.fail_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_copy();
    int nw, fw, lw, fa, nf;
    bit ok, hf;
    int n = 0;
    do_reset();
    bus.halt_ack_a_i = 1'b1;
    bus.halt_ack_b_i = 1'b1;
    pulse_mismatch();
    while (bus.sgpr_raddr_o !== 5'd15 && n < 60) begin
      tick();
      n++;
    end
    total++; if (bus.sgpr_raddr_o !== 5'd15) begin bad++; $display("FAIL midcopy_reach raddr=%0d want=15", bus.sgpr_raddr_o); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.halt_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.flush_o !== 1'b0 ||
                 bus.rf_we_o !== 1'b0 || bus.sgpr_raddr_o !== 5'd0 || bus.rf_wdata_o !== 32'd0) begin
      bad++; $display("FAIL midcopy_abort halt=%b busy=%b flush=%b we=%b raddr=%0d wdata=%0d want all 0",
                      bus.halt_o, bus.busy_o, bus.flush_o, bus.rf_we_o, bus.sgpr_raddr_o, bus.rf_wdata_o); end
    total++; if (bus.err_count_o !== 8'd0) begin bad++; $display("FAIL midcopy_err_clr got=%0d want=0", bus.err_count_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_mismatch();
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL midcopy_err got=%0d want=1", bus.err_count_o); end
    watch(1, 80, nw, ok, fw, lw, fa, nf, hf);
    total++; if (nw !== 31 || ok !== 1'b1 || fw !== 4) begin
      bad++; $display("FAIL midcopy_restart n=%0d ok=%b first=%0d want 31 1 4", nw, ok, fw); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    int timeouts = 0;
    do_reset();
    sbus.halt_ack_a_i = 1'b1;
    sbus.halt_ack_b_i = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      int n = 0;
      sbus.mismatch_i = 1'b1;
      tick();
      sbus.mismatch_i = 1'b0;
      while (sbus.busy_o && n < 100) begin
        tick();
        n++;
      end
      if (sbus.busy_o) timeouts++;
      if (i == 200) begin
        total++; if (sbus.err_count_o !== 8'd200) begin bad++; $display("FAIL sat_mid got=%0d want=200", sbus.err_count_o); end
      end
    end
    total++; if (timeouts !== 0) begin bad++; $display("FAIL sat_timeouts got=%0d want=0", timeouts); end
    total++; if (sbus.err_count_o !== 8'd255 || sbus.fail_o !== 1'b0) begin
      bad++; $display("FAIL sat_final err=%0d fail=%b want 255 0", sbus.err_count_o, sbus.fail_o); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_skewed_acks();
    test_halt_timeout();
    test_retry_budget();
    test_reset_mid_copy();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
